// File: rtl/pos_cell_ctrl.sv
// Cell RAM controller: streams a particle cell (count word at address 0) and merges write-backs.
// Optional macro POS_CELL_WR_PREEMPT_EN lets a write-back steal one RAM slot during a burst.
module pos_cell_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_grant,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

`ifdef POS_CELL_WR_PREEMPT_EN
    localparam bit PREEMPT_EN = 1'b1;
`else
    localparam bit PREEMPT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CNT_WAIT, BURST, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                state_q, state_d;
    logic [1:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] burst_q, burst_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_rden_q, ram_rden_d;
    logic                  ram_wren_q, ram_wren_d;
    logic                  tag1_valid_q, tag1_valid_d;
    logic                  tag2_valid_q, tag2_valid_d;
    logic [ADDR_WIDTH-1:0] tag1_idx_q, tag1_idx_d;
    logic [ADDR_WIDTH-1:0] tag2_idx_q, tag2_idx_d;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] cnt_raw;

    assign cnt_raw = ram_q[ADDR_WIDTH-1:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        wait_d     = wait_q;
        count_d    = count_q;
        burst_d    = burst_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_rden_d = 1'b0;
        ram_wren_d = 1'b0;
        grant      = 1'b0;
        // Address 0 is the count read, so only non-zero read addresses enter the tag pipeline.
        tag1_valid_d = ram_rden_q && (ram_addr_q != '0);
        tag1_idx_d   = ram_addr_q;
        tag2_valid_d = tag1_valid_q;
        tag2_idx_d   = tag1_idx_q;

        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    ram_addr_d = '0;
                    ram_rden_d = 1'b1;
                    wait_d     = '0;
                    count_d    = '0;
                    burst_d    = '0;
                    state_d    = CNT_WAIT;
                end else if (wr_req) begin
                    grant      = 1'b1;
                    ram_addr_d = wr_addr;
                    ram_data_d = wr_data;
                    ram_wren_d = 1'b1;
                end
            end
            CNT_WAIT: begin
                if (wait_q == 2'd2) begin
                    count_d = (cnt_raw > MAX_ADDR) ? MAX_ADDR : cnt_raw;
                    if (count_d == '0) begin
                        state_d = DONE;
                    end else begin
                        ram_addr_d = ADDR_WIDTH'(1);
                        ram_rden_d = 1'b1;
                        burst_d    = ADDR_WIDTH'(1);
                        state_d    = BURST;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            BURST: begin
                // burst_q is the last address presented; it holds while a write takes the slot.
                if (PREEMPT_EN && wr_req) begin
                    grant      = 1'b1;
                    ram_addr_d = wr_addr;
                    ram_data_d = wr_data;
                    ram_wren_d = 1'b1;
                end else if (burst_q < count_q) begin
                    ram_addr_d = burst_q + 1'b1;
                    ram_rden_d = 1'b1;
                    burst_d    = burst_q + 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!tag1_valid_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            count_q      <= '0;
            burst_q      <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_rden_q   <= 1'b0;
            ram_wren_q   <= 1'b0;
            tag1_valid_q <= 1'b0;
            tag2_valid_q <= 1'b0;
            tag1_idx_q   <= '0;
            tag2_idx_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            wait_q       <= wait_d;
            count_q      <= count_d;
            burst_q      <= burst_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_rden_q   <= ram_rden_d;
            ram_wren_q   <= ram_wren_d;
            tag1_valid_q <= tag1_valid_d;
            tag2_valid_q <= tag2_valid_d;
            tag1_idx_q   <= tag1_idx_d;
            tag2_idx_q   <= tag2_idx_d;
        end
    end

    // Busy rises once the count read is in flight and stays up through DONE.
    assign rd_busy   = (state_q != IDLE) && !((state_q == CNT_WAIT) && (wait_q == 2'd0));
    assign rd_done   = (state_q == DONE);
    assign wr_grant  = grant && !rst;
    assign out_valid = tag2_valid_q;
    assign out_index = tag2_idx_q;
    assign out_data  = tag2_valid_q ? ram_q : '0;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_rden  = ram_rden_q;
    assign ram_wren  = ram_wren_q;

endmodule

// File: tb/tb_pos_cell_ctrl.sv
// Self-checking bench for pos_cell_ctrl: RAM model with 2-cycle latency and an output scoreboard.
module tb_pos_cell_ctrl;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req = 1'b0;
    logic          rd_busy, rd_done, out_valid, wr_grant, ram_rden, ram_wren;
    logic [DW-1:0] out_data, ram_data, wr_data, count_word;
    logic [AW-1:0] out_index, ram_addr, wr_addr;
    logic          wr_req;
    logic [DW-1:0] p1, ram_q;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int wr_asked = 0;
    int wr_granted = 0;
    int grant_cyc = -1;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [DW-1:0] wr_mem [0:255];
    bit            written [0:255];

    logic [AW-1:0] addr_log [0:15];
    bit            rden_log [0:15];
    bit            wren_log [0:15];
    int done_off, busy_n, valid_n, max_addr, a_cyc;

    pos_cell_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_busy(rd_busy), .rd_done(rd_done),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int i);
        return {32'(i * 7 + 3), 32'hC0DE_0000 | 32'(i), ~32'(i)};
    endfunction

    // Cell RAM model: read data appears two cycles after the address cycle.
    always @(posedge clk) begin
        if (ram_wren) begin
            wr_mem[ram_addr]  <= ram_data;
            written[ram_addr] <= 1'b1;
        end
        if (!ram_rden)                p1 <= '0;
        else if (ram_addr == '0)      p1 <= count_word;
        else if (written[ram_addr])   p1 <= wr_mem[ram_addr];
        else                          p1 <= pat(int'(ram_addr));
        ram_q <= p1;
    end

    // Write requester: holds wr_req until a grant is seen, then drops it.
    assign wr_req = (wr_asked != wr_granted);
    always @(posedge clk) begin
        if (wr_grant === 1'b1) begin
            grant_cyc = cyc;
            #1 wr_granted++;
        end
    end

    // Scoreboard and RAM-port monitor.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (ram_rden && ram_wren) begin
                errors++;
                $display("FAIL rden_wren_overlap: cycle %0d addr %0d", cyc, ram_addr);
            end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got index %0d, expected no output", out_index);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_index !== mon_e.idx || out_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL out_word: got idx %0d data %h, expected idx %0d data %h",
                                 out_index, out_data, mon_e.idx, mon_e.data);
                    end
                end
            end
        end
    end

    // Starts a read at cycle A-1 and logs per-offset activity until rd_done+2 (bounded).
    // wr_off: -1 no write, -2 raise wr_req together with rd_req, >=0 raise at that offset.
    task automatic run_read(input logic [DW-1:0] cword, input int exp_cnt, input int wr_off);
        int off;
        count_word = cword;
        @(posedge clk); #1;
        rd_req = 1'b1;
        for (int k = 1; k <= exp_cnt; k++) sb.push_back('{idx: AW'(k), data: pat(k)});
        if (wr_off == -2) wr_asked++;
        @(posedge clk); #1;
        rd_req = 1'b0;
        a_cyc = cyc;
        done_off = -1; busy_n = 0; valid_n = 0; max_addr = 0;
        for (int i = 0; i < 16; i++) begin
            addr_log[i] = '0; rden_log[i] = 1'b0; wren_log[i] = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            off = cyc - a_cyc;
            if (off < 16) begin
                addr_log[off] = ram_addr; rden_log[off] = ram_rden; wren_log[off] = ram_wren;
            end
            if (rd_busy) busy_n++;
            if (out_valid) valid_n++;
            if (ram_rden && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            if (rd_done && done_off < 0) done_off = off;
            if (off == wr_off) wr_asked++;
            if (done_off >= 0 && off >= done_off + 2) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_busy, rd_done, out_valid, out_data, out_index, wr_grant,
             ram_addr, ram_data, ram_rden, ram_wren} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy %b done %b valid %b rden %b wren %b addr %0d, expected all zero",
                     rd_busy, rd_done, out_valid, ram_rden, ram_wren, ram_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_busy !== 1'b0 || ram_rden !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy %b rden %b, expected 0 0", rd_busy, ram_rden);
        end
    endtask

    task automatic test_burst5();
        run_read(96'd5, 5, -1);
        checks++;
        if (!(rden_log[0] && addr_log[0] == '0)) begin
            errors++;
            $display("FAIL count_read: rden %b addr %0d at A, expected 1 0", rden_log[0], addr_log[0]);
        end
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (!(rden_log[k+2] && addr_log[k+2] == AW'(k))) begin
                errors++;
                $display("FAIL burst_addr: A+%0d rden %b addr %0d, expected 1 %0d",
                         k + 2, rden_log[k+2], addr_log[k+2], k);
            end
        end
        checks++;
        if (done_off !== 10) begin
            errors++;
            $display("FAIL burst5_done: rd_done at A+%0d, expected A+10", done_off);
        end
        checks++;
        if (busy_n !== 10 || valid_n !== 5) begin
            errors++;
            $display("FAIL burst5_counts: busy %0d valid %0d, expected 10 5", busy_n, valid_n);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL burst5_drain: %0d words undelivered, expected 0", sb.size());
        end
    endtask

    task automatic test_count_zero();
        run_read(96'd0, 0, -1);
        checks++;
        if (done_off !== 3) begin
            errors++;
            $display("FAIL zero_done: rd_done at A+%0d, expected A+3", done_off);
        end
        checks++;
        if (busy_n !== 3 || valid_n !== 0) begin
            errors++;
            $display("FAIL zero_counts: busy %0d valid %0d, expected 3 0", busy_n, valid_n);
        end
    endtask

    task automatic test_saturate();
        run_read(96'd255, PN - 1, -1);
        checks++;
        if (valid_n !== PN - 1 || max_addr !== PN - 1) begin
            errors++;
            $display("FAIL saturate: valid %0d max_addr %0d, expected %0d %0d",
                     valid_n, max_addr, PN - 1, PN - 1);
        end
        checks++;
        if (done_off !== PN - 1 + 5 || sb.size() !== 0) begin
            errors++;
            $display("FAIL saturate_done: done A+%0d left %0d, expected A+%0d 0",
                     done_off, sb.size(), PN + 4);
        end
    endtask

    task automatic test_rd_wr_priority();
        int exp_g;
        wr_addr = 8'd200;
        wr_data = pat(999);
        run_read(96'd5, 5, -2);
        checks++;
        if (!(rden_log[0] && addr_log[0] == '0 && !wren_log[0])) begin
            errors++;
            $display("FAIL rd_priority: A rden %b wren %b addr %0d, expected 1 0 0",
                     rden_log[0], wren_log[0], addr_log[0]);
        end
`ifdef POS_CELL_WR_PREEMPT_EN
        exp_g = 3;
`else
        exp_g = done_off + 1;
`endif
        checks++;
        if (grant_cyc - a_cyc !== exp_g) begin
            errors++;
            $display("FAIL wr_grant_time: grant at A+%0d, expected A+%0d", grant_cyc - a_cyc, exp_g);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (!written[200] || wr_mem[200] !== pat(999) || wr_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_data: written %b data %h req %b, expected 1 %h 0",
                     written[200], wr_mem[200], wr_req, pat(999));
        end
    endtask

`ifdef POS_CELL_WR_PREEMPT_EN
    task automatic test_preempt();
        wr_addr = 8'd100;
        wr_data = pat(555);
        run_read(96'd5, 5, 4);
        checks++;
        if (grant_cyc - a_cyc !== 4 || !(wren_log[5] && addr_log[5] == 8'd100)) begin
            errors++;
            $display("FAIL preempt_slot: grant A+%0d wren %b addr %0d, expected A+4 1 100",
                     grant_cyc - a_cyc, wren_log[5], addr_log[5]);
        end
        checks++;
        if (!(rden_log[6] && addr_log[6] == 8'd3)) begin
            errors++;
            $display("FAIL preempt_hold: A+6 rden %b addr %0d, expected 1 3", rden_log[6], addr_log[6]);
        end
        checks++;
        if (done_off !== 11 || valid_n !== 5 || busy_n !== 11 || sb.size() !== 0) begin
            errors++;
            $display("FAIL preempt_counts: done %0d valid %0d busy %0d left %0d, expected 11 5 11 0",
                     done_off, valid_n, busy_n, sb.size());
        end
    endtask
`endif

    task automatic test_mid_burst_reset();
        count_word = 96'd5;
        @(posedge clk); #1;
        rd_req = 1'b1;
        for (int k = 1; k <= 5; k++) sb.push_back('{idx: AW'(k), data: pat(k)});
        @(posedge clk); #1;
        rd_req = 1'b0;
        a_cyc = cyc;
        repeat (5) @(negedge clk);
        checks++;
        if (ram_addr !== 8'd2 || ram_rden !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_addr: addr %0d rden %b, expected 2 1", ram_addr, ram_rden);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_busy, rd_done, out_valid, out_data, out_index, wr_grant,
             ram_addr, ram_data, ram_rden, ram_wren} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy %b valid %b rden %b addr %0d, expected all zero",
                     rd_busy, out_valid, ram_rden, ram_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        run_read(96'd5, 5, -1);
        checks++;
        if (!(rden_log[0] && addr_log[0] == '0) || done_off !== 10 || valid_n !== 5) begin
            errors++;
            $display("FAIL restart: rden %b addr %0d done %0d valid %0d, expected 1 0 10 5",
                     rden_log[0], addr_log[0], done_off, valid_n);
        end
    endtask

    initial begin
        wr_addr = '0;
        wr_data = '0;
        count_word = '0;
        test_reset();
        test_burst5();
        test_count_zero();
        test_saturate();
        test_rd_wr_priority();
`ifdef POS_CELL_WR_PREEMPT_EN
        test_preempt();
`endif
        test_mid_burst_reset();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
